seq_ctrl: RTL and testbench

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/seq_ctrl_pkg.sv | 53 +++++
 rtl/seq_ctrl_if.sv | 37 +++
 rtl/seq_ctrl_wait.sv | 26 ++
 rtl/seq_ctrl.sv | 127 ++++++++++++
 tb/tb_seq_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared constants for the sequencer: state codes, opcodes, mode masks and small decode helpers.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StNone   = 3'd0,
        StRst1   = 3'd1,
        StFetch  = 3'd2,
        StDecode = 3'd3,
        StExec   = 3'd4,
        StMem    = 3'd5,
        StWb     = 3'd6,
        StHalt   = 3'd7
    } state_e;

    // Fields are zero-extended to this width before decoding so helpers stay width-agnostic.
    typedef logic [31:0] word_t;

    localparam int unsigned OpNoop = 0;
    localparam int unsigned OpLod  = 1;
    localparam int unsigned OpStr  = 2;
    localparam int unsigned OpSwp  = 3;
    localparam int unsigned OpBra  = 4;
    localparam int unsigned OpBrr  = 5;
    localparam int unsigned OpBne  = 6;
    localparam int unsigned OpBnr  = 7;
    localparam int unsigned OpAlu  = 8;
    localparam int unsigned OpHlt  = 15;

    localparam int unsigned ModeZero  = 0;
    localparam int unsigned ModeOne   = 1;
    localparam int unsigned ModeEight = 8;
    localparam int unsigned ModeNine  = 9;

    function automatic logic is_branch(word_t op);
        return (op >= OpBra) && (op <= OpBnr);
    endfunction

    function automatic logic is_mem(word_t op);
        return (op == OpLod) || (op == OpStr);
    endfunction

    function automatic logic [1:0] alu_sel(word_t op, word_t mm);
        if (op == OpAlu) begin
            return (mm == ModeEight) ? 2'b01 : 2'b00;
        end
        if (is_mem(op)) begin
            if (mm == ModeEight) return 2'b11;
            if (mm == ModeOne || mm == ModeNine) return 2'b01;
        end
        return 2'b10;
    endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Controller <-> datapath signal bundle; master is the sequencer, slave is the datapath.
interface seq_ctrl_if #(
    parameter int unsigned CCW = 4,
    parameter int unsigned OPW = 4
);
    logic [OPW-1:0] opcode;
    logic [CCW-1:0] mm;
    logic [CCW-1:0] stat;
    logic           mem_ack;
    logic           run;

    logic           ir_load;
    logic           pc_write;
    logic           pc_sel;
    logic           br_sel;
    logic           rb_sel;
    logic           rf_we;
    logic           dm_we;
    logic           mem_req;
    logic [1:0]     alu_op;
    logic [1:0]     wb_sel;
    logic [2:0]     state;
    logic           halted;
    logic           mem_err;

    modport master (
        input  opcode, mm, stat, mem_ack, run,
        output ir_load, pc_write, pc_sel, br_sel, rb_sel, rf_we, dm_we, mem_req,
        output alu_op, wb_sel, state, halted, mem_err
    );

    modport slave (
        output opcode, mm, stat, mem_ack, run,
        input  ir_load, pc_write, pc_sel, br_sel, rb_sel, rf_we, dm_we, mem_req,
        input  alu_op, wb_sel, state, halted, mem_err
    );
endinterface

// File: rtl/seq_ctrl_wait.sv
// MEM-state wait counter; flags the cycle on which the wait budget would be exhausted.
module seq_ctrl_wait #(
    parameter int unsigned MEM_TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic timeout
);
    localparam int unsigned CW = (MEM_TMO < 1) ? 1 : $clog2(MEM_TMO + 1);
    localparam logic [CW-1:0] Last = CW'((MEM_TMO == 0) ? 0 : MEM_TMO - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Counter would reach MEM_TMO on this edge without an ack.
    assign timeout = inc && (cnt_q == Last);
endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb FSM driving datapath strobes.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned CCW     = 4,
    parameter int unsigned OPW     = 4,
    parameter int unsigned MEM_TMO = 15
) (
    input logic        clk,
    input logic        rst,
    seq_ctrl_if.master bus
);
    state_e         state_q;
    logic [OPW-1:0] op_q;
    logic [CCW-1:0] mm_q;
    logic           mem_err_q;
    logic           timeout;
    logic           wait_inc;
    logic           cond_hit;
    word_t          op_live;
    word_t          op_lat;
    word_t          mm_lat;

    assign op_live  = word_t'(bus.opcode);
    assign op_lat   = word_t'(op_q);
    assign mm_lat   = word_t'(mm_q);
    assign cond_hit = |(bus.stat & bus.mm);
    assign wait_inc = (state_q == StMem) && is_mem(op_lat) && !bus.mem_ack;

    seq_ctrl_wait #(
        .MEM_TMO(MEM_TMO)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != StMem),
        .inc    (wait_inc),
        .timeout(timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRst1;
            op_q      <= OPW'(OpNoop);
            mm_q      <= CCW'(ModeZero);
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                StRst1:  state_q <= StFetch;
                StFetch: state_q <= StDecode;
                StDecode: begin
                    op_q <= bus.opcode;
                    mm_q <= bus.mm;
                    if (op_live == OpHlt) begin
                        state_q <= StHalt;
                    end else if (is_branch(op_live)) begin
                        state_q <= StFetch;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: state_q <= StMem;
                StMem: begin
                    if (timeout) begin
                        mem_err_q <= 1'b1;
                        state_q   <= StHalt;
                    end else if (!is_mem(op_lat) || bus.mem_ack) begin
                        state_q <= StWb;
                    end
                end
                StWb: state_q <= StFetch;
                StHalt: begin
                    if (bus.run) state_q <= StFetch;
                end
                default: state_q <= StRst1;
            endcase
        end
    end

    always_comb begin
        logic taken;
        taken        = 1'b0;
        bus.ir_load  = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.br_sel   = 1'b0;
        bus.rb_sel   = 1'b0;
        bus.rf_we    = 1'b0;
        bus.dm_we    = 1'b0;
        bus.mem_req  = 1'b0;
        bus.alu_op   = 2'b00;
        bus.wb_sel   = 2'b00;
        case (state_q)
            StFetch: begin
                bus.ir_load  = 1'b1;
                bus.pc_write = 1'b1;
            end
            StDecode: begin
                bus.rb_sel = (op_live == OpStr) || (op_live == OpSwp);
                // Branch resolution looks at live inputs; fields are only latched at the end of DECODE.
                if (is_branch(op_live)) begin
                    taken = ((op_live == OpBra) || (op_live == OpBrr)) ? cond_hit : !cond_hit;
                    bus.pc_write = taken;
                    bus.pc_sel   = taken;
                    bus.br_sel   = taken && ((op_live == OpBra) || (op_live == OpBne));
                end
            end
            StExec: bus.alu_op = alu_sel(op_lat, mm_lat);
            StMem: begin
                bus.mem_req = is_mem(op_lat);
                bus.dm_we   = (op_lat == OpStr);
            end
            StWb: begin
                bus.rf_we = (op_lat == OpAlu) || (op_lat == OpLod) || (op_lat == OpSwp);
                if (op_lat == OpLod) begin
                    bus.wb_sel = 2'b01;
                end else if (op_lat == OpSwp) begin
                    bus.wb_sel = 2'b11;
                end
            end
            default: ;
        endcase
    end

    assign bus.state   = state_q;
    assign bus.halted  = (state_q == StHalt);
    assign bus.mem_err = mem_err_q;
endmodule

// File: tb/tb_seq_ctrl.sv
// Directed scoreboard bench for seq_ctrl: stimulus queues per-cycle expectations, monitor checks them.
module tb_seq_ctrl;
    logic clk;
    logic rst;

    seq_ctrl_if #(.CCW(4), .OPW(4)) bus ();

    seq_ctrl #(
        .CCW    (4),
        .OPW    (4),
        .MEM_TMO(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe byte: {ir_load, pc_write, pc_sel, br_sel, rb_sel, rf_we, dm_we, mem_req}
    localparam logic [7:0] SbNone   = 8'h00;
    localparam logic [7:0] SbFetch  = 8'hC0;
    localparam logic [7:0] SbTaken  = 8'h70;
    localparam logic [7:0] SbTakenR = 8'h60;
    localparam logic [7:0] SbRb     = 8'h08;
    localparam logic [7:0] SbRf     = 8'h04;
    localparam logic [7:0] SbMemWr  = 8'h03;
    localparam logic [7:0] SbMemRd  = 8'h01;

    logic [16:0] exp_q[$];
    string       nm_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_v;
    logic [16:0] act_v;
    string       exp_n;

    function automatic logic [16:0] ev(input logic [2:0] st, input logic [7:0] sb,
                                       input logic [1:0] alu, input logic [1:0] wb,
                                       input logic err);
        return {st, sb, alu, wb, (st == 3'd7), err};
    endfunction

    task automatic cyc(input string nm, input logic [16:0] e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            exp_n = nm_q.pop_front();
            act_v = {bus.state, bus.ir_load, bus.pc_write, bus.pc_sel, bus.br_sel, bus.rb_sel,
                     bus.rf_we, bus.dm_we, bus.mem_req, bus.alu_op, bus.wb_sel, bus.halted,
                     bus.mem_err};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", exp_n, act_v, exp_v);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.opcode  = 4'd0;
        bus.mm      = 4'd0;
        bus.stat    = 4'd0;
        bus.mem_ack = 1'b0;
        bus.run     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rst1", ev(3'd1, SbNone, 2'b00, 2'b00, 1'b0));

        // ALU, mm=0
        bus.opcode = 4'd8;
        bus.mm     = 4'd0;
        cyc("alu0_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("alu0_decode", ev(3'd3, SbNone, 2'b00, 2'b00, 1'b0));
        cyc("alu0_exec", ev(3'd4, SbNone, 2'b00, 2'b00, 1'b0));
        cyc("alu0_mem", ev(3'd5, SbNone, 2'b00, 2'b00, 1'b0));
        cyc("alu0_wb", ev(3'd6, SbRf, 2'b00, 2'b00, 1'b0));

        // ALU, mm=8; inputs change after DECODE and must be ignored
        bus.mm = 4'd8;
        cyc("alu8_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("alu8_decode", ev(3'd3, SbNone, 2'b00, 2'b00, 1'b0));
        bus.opcode = 4'd15;
        bus.mm     = 4'd1;
        cyc("alu8_exec", ev(3'd4, SbNone, 2'b01, 2'b00, 1'b0));
        cyc("alu8_mem", ev(3'd5, SbNone, 2'b00, 2'b00, 1'b0));
        cyc("alu8_wb", ev(3'd6, SbRf, 2'b00, 2'b00, 1'b0));

        // Branches
        bus.opcode = 4'd4;
        bus.mm     = 4'b0100;
        bus.stat   = 4'b0100;
        cyc("bra_t_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("bra_t_decode", ev(3'd3, SbTaken, 2'b00, 2'b00, 1'b0));
        bus.stat = 4'b0001;
        cyc("bra_n_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("bra_n_decode", ev(3'd3, SbNone, 2'b00, 2'b00, 1'b0));
        bus.opcode = 4'd7;
        bus.mm     = 4'b0010;
        bus.stat   = 4'b0001;
        cyc("bnr_t_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("bnr_t_decode", ev(3'd3, SbTakenR, 2'b00, 2'b00, 1'b0));
        bus.opcode = 4'd6;
        bus.mm     = 4'b0011;
        bus.stat   = 4'b0010;
        cyc("bne_n_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("bne_n_decode", ev(3'd3, SbNone, 2'b00, 2'b00, 1'b0));

        // STR mm=8, ack on 4th MEM cycle; ack during EXEC is ignored
        bus.opcode = 4'd2;
        bus.mm     = 4'd8;
        bus.stat   = 4'd0;
        cyc("str_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("str_decode", ev(3'd3, SbRb, 2'b00, 2'b00, 1'b0));
        bus.mem_ack = 1'b1;
        cyc("str_exec", ev(3'd4, SbNone, 2'b11, 2'b00, 1'b0));
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) cyc("str_mem_wait", ev(3'd5, SbMemWr, 2'b00, 2'b00, 1'b0));
        bus.mem_ack = 1'b1;
        cyc("str_mem_ack", ev(3'd5, SbMemWr, 2'b00, 2'b00, 1'b0));
        bus.mem_ack = 1'b0;
        cyc("str_wb", ev(3'd6, SbNone, 2'b00, 2'b00, 1'b0));

        // LOD mm=9, zero-wait
        bus.opcode = 4'd1;
        bus.mm     = 4'd9;
        cyc("lod9_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("lod9_decode", ev(3'd3, SbNone, 2'b00, 2'b00, 1'b0));
        cyc("lod9_exec", ev(3'd4, SbNone, 2'b01, 2'b00, 1'b0));
        bus.mem_ack = 1'b1;
        cyc("lod9_mem", ev(3'd5, SbMemRd, 2'b00, 2'b00, 1'b0));
        bus.mem_ack = 1'b0;
        cyc("lod9_wb", ev(3'd6, SbRf, 2'b00, 2'b01, 1'b0));

        // SWP mm=0
        bus.opcode = 4'd3;
        bus.mm     = 4'd0;
        cyc("swp_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("swp_decode", ev(3'd3, SbRb, 2'b00, 2'b00, 1'b0));
        cyc("swp_exec", ev(3'd4, SbNone, 2'b10, 2'b00, 1'b0));
        cyc("swp_mem", ev(3'd5, SbNone, 2'b00, 2'b00, 1'b0));
        cyc("swp_wb", ev(3'd6, SbRf, 2'b00, 2'b11, 1'b0));

        // Unlisted opcode behaves as NOOP
        bus.opcode = 4'd12;
        cyc("nop_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("nop_decode", ev(3'd3, SbNone, 2'b00, 2'b00, 1'b0));
        cyc("nop_exec", ev(3'd4, SbNone, 2'b10, 2'b00, 1'b0));
        cyc("nop_mem", ev(3'd5, SbNone, 2'b00, 2'b00, 1'b0));
        cyc("nop_wb", ev(3'd6, SbNone, 2'b00, 2'b00, 1'b0));

        // LOD with no ack: 15 MEM cycles then timeout into HALT
        bus.opcode = 4'd1;
        bus.mm     = 4'd0;
        cyc("tmo_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));
        cyc("tmo_decode", ev(3'd3, SbNone, 2'b00, 2'b00, 1'b0));
        cyc("tmo_exec", ev(3'd4, SbNone, 2'b10, 2'b00, 1'b0));
        for (int i = 0; i < 15; i++) cyc("tmo_mem", ev(3'd5, SbMemRd, 2'b00, 2'b00, 1'b0));
        cyc("tmo_halt", ev(3'd7, SbNone, 2'b00, 2'b00, 1'b1));
        cyc("tmo_halt_hold", ev(3'd7, SbNone, 2'b00, 2'b00, 1'b1));
        bus.run = 1'b1;
        cyc("tmo_halt_run", ev(3'd7, SbNone, 2'b00, 2'b00, 1'b1));
        bus.run    = 1'b0;
        bus.opcode = 4'd15;
        cyc("tmo_refetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b1));

        // HLT, then restart with run; mem_err stays set
        cyc("hlt_decode", ev(3'd3, SbNone, 2'b00, 2'b00, 1'b1));
        cyc("hlt_halt", ev(3'd7, SbNone, 2'b00, 2'b00, 1'b1));
        cyc("hlt_hold", ev(3'd7, SbNone, 2'b00, 2'b00, 1'b1));
        bus.run = 1'b1;
        cyc("hlt_run", ev(3'd7, SbNone, 2'b00, 2'b00, 1'b1));
        bus.run    = 1'b0;
        bus.opcode = 4'd2;
        bus.mm     = 4'd8;
        cyc("hlt_refetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b1));

        // Reset mid-MEM clears everything, including mem_err
        cyc("rmem_decode", ev(3'd3, SbRb, 2'b00, 2'b00, 1'b1));
        cyc("rmem_exec", ev(3'd4, SbNone, 2'b11, 2'b00, 1'b1));
        cyc("rmem_mem1", ev(3'd5, SbMemWr, 2'b00, 2'b00, 1'b1));
        rst = 1'b1;
        cyc("rmem_mem2", ev(3'd5, SbMemWr, 2'b00, 2'b00, 1'b1));
        rst        = 1'b0;
        bus.opcode = 4'd15;
        cyc("rmem_rst1", ev(3'd1, SbNone, 2'b00, 2'b00, 1'b0));
        cyc("rmem_fetch", ev(3'd2, SbFetch, 2'b00, 2'b00, 1'b0));

        // rst and run together in HALT: reset wins
        cyc("rr_decode", ev(3'd3, SbNone, 2'b00, 2'b00, 1'b0));
        rst     = 1'b1;
        bus.run = 1'b1;
        cyc("rr_halt", ev(3'd7, SbNone, 2'b00, 2'b00, 1'b0));
        rst     = 1'b0;
        bus.run = 1'b0;
        cyc("rr_rst1", ev(3'd1, SbNone, 2'b00, 2'b00, 1'b0));

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
